// File: rtl/enemy_spawner_pkg.sv
// ============================================================================
//  Module      : enemy_spawner_pkg
//  Description : Shared FSM states, LFSR constants and screen defaults for the
//                enemy spawner and the game top level.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package enemy_spawner_pkg;

    localparam int c_screen_w     = 640;
    localparam int c_screen_h     = 480;
    localparam int c_enemy_size   = 20;
    localparam int c_avoid_margin = 40;

    // x^10 + x^7 + 1 -> feedback from bits 9 and 6
    localparam logic [9:0] c_lfsr_seed = 10'h2A5;
    localparam logic [9:0] c_lfsr_taps = 10'h240;

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_scan   = 3'd1;
    localparam logic [2:0] c_st_gen_x  = 3'd2;
    localparam logic [2:0] c_st_gen_y  = 3'd3;
    localparam logic [2:0] c_st_commit = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = c_st_idle,
        ST_SCAN   = c_st_scan,
        ST_GEN_X  = c_st_gen_x,
        ST_GEN_Y  = c_st_gen_y,
        ST_COMMIT = c_st_commit
    } spawn_state_t;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'b0, v[i]};
        end
        return n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/enemy_spawner_lfsr10.sv
// ============================================================================
//  Module      : lfsr10
//  Description : Free-running 10-bit Fibonacci LFSR (x^10 + x^7 + 1).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr10
    import enemy_spawner_pkg::*;
#(
    parameter logic [9:0] SEED = c_lfsr_seed
) (
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] o_value
);

    logic [9:0] r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SEED;
        end else begin
            r_state <= {r_state[8:0], ^(r_state & c_lfsr_taps)};
        end
    end

    assign o_value = r_state;

endmodule

`default_nettype wire

// File: rtl/enemy_spawner.sv
// ============================================================================
//  Module      : enemy_spawner
//  Description : Fills free enemy slots with random on-screen positions at a
//                throttled spawn rate; supports per-slot kills.
//                Option macro ENEMY_SPAWNER_AVOID_EN keeps spawns clear of
//                the player box (+40 px on every side).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module enemy_spawner
    import enemy_spawner_pkg::*;
#(
    parameter int MAX_ENEMIES = 10,
    parameter int SCREEN_W    = c_screen_w,
    parameter int SCREEN_H    = c_screen_h,
    parameter int ENEMY_SIZE  = c_enemy_size,
    parameter int SPAWN_GAP   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      spawn_tick,
    input  logic                      kill_valid,
    input  logic [3:0]                kill_idx,
    input  logic [9:0]                player_x,
    input  logic [9:0]                player_y,
    output logic [MAX_ENEMIES-1:0]    enemy_active,
    output logic [10*MAX_ENEMIES-1:0] enemy_x_flat,
    output logic [10*MAX_ENEMIES-1:0] enemy_y_flat,
    output logic                      spawn_valid,
    output logic [3:0]                spawn_idx,
    output logic [4:0]                active_count
);

    localparam int               c_gap_w = (SPAWN_GAP < 2) ? 1 : $clog2(SPAWN_GAP + 1);
    localparam logic [c_gap_w-1:0] c_gap_max = c_gap_w'(SPAWN_GAP);
    localparam logic [10:0]      c_x_lim = 11'(SCREEN_W - ENEMY_SIZE);
    localparam logic [10:0]      c_y_lim = 11'(SCREEN_H - ENEMY_SIZE);

    spawn_state_t           r_state;
    logic [c_gap_w-1:0]     r_gap;
    logic [3:0]             r_slot;
    logic [9:0]             r_cand_x;
    logic [9:0]             r_cand_y;
    logic [MAX_ENEMIES-1:0] r_active;
    logic [MAX_ENEMIES-1:0] w_active_next;
    logic [4:0]             r_count;
    logic                   r_spawn_valid;
    logic [3:0]             r_spawn_idx;
    logic [9:0]             w_lfsr;
    logic                   w_commit;
    logic                   w_free_found;
    logic [3:0]             w_free_idx;
    logic                   w_overlap;

    lfsr10 #(
        .SEED    (c_lfsr_seed)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .o_value (w_lfsr)
    );

    assign w_commit = (r_state == ST_COMMIT);

    // Lowest-index free slot wins because the loop runs downward.
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int i = MAX_ENEMIES - 1; i >= 0; i--) begin
            if (!r_active[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = 4'(i);
            end
        end
    end

    // Kill only matches in-range indices; the committing slot is never active.
    always_comb begin
        w_active_next = r_active;
        for (int i = 0; i < MAX_ENEMIES; i++) begin
            if (kill_valid && (kill_idx == 4'(i))) begin
                w_active_next[i] = 1'b0;
            end
            if (w_commit && (r_slot == 4'(i))) begin
                w_active_next[i] = 1'b1;
            end
        end
    end

`ifdef ENEMY_SPAWNER_AVOID_EN
    localparam logic [11:0] c_reach = 12'(ENEMY_SIZE + c_avoid_margin);
    logic [11:0] w_ex;
    logic [11:0] w_ey;
    logic [11:0] w_px;
    logic [11:0] w_py;
    assign w_ex = {2'b0, r_cand_x};
    assign w_ey = {2'b0, w_lfsr};
    assign w_px = {2'b0, player_x};
    assign w_py = {2'b0, player_y};
    assign w_overlap = (w_ex + c_reach > w_px) && (w_ex < w_px + c_reach) &&
                       (w_ey + c_reach > w_py) && (w_ey < w_py + c_reach);
`else
    logic w_unused_player;
    assign w_unused_player = ^{player_x, player_y};
    assign w_overlap       = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gap <= '0;
        end else if (r_spawn_valid) begin
            r_gap <= '0;
        end else if (spawn_tick && (r_gap != c_gap_max)) begin
            r_gap <= r_gap + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_slot        <= '0;
            r_cand_x      <= '0;
            r_cand_y      <= '0;
            r_active      <= '0;
            r_count       <= '0;
            r_spawn_valid <= 1'b0;
            r_spawn_idx   <= '0;
        end else begin
            r_spawn_valid <= 1'b0;
            r_active      <= w_active_next;
            r_count       <= popcount16(16'(w_active_next));
            case (r_state)
                ST_IDLE: begin
                    if (spawn_tick && (r_gap == c_gap_max)) begin
                        r_state <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (w_free_found) begin
                        r_slot  <= w_free_idx;
                        r_state <= ST_GEN_X;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_GEN_X: begin
                    if ({1'b0, w_lfsr} < c_x_lim) begin
                        r_cand_x <= w_lfsr;
                        r_state  <= ST_GEN_Y;
                    end
                end
                ST_GEN_Y: begin
                    if ({1'b0, w_lfsr} < c_y_lim) begin
                        if (w_overlap) begin
                            r_state <= ST_GEN_X;
                        end else begin
                            r_cand_y <= w_lfsr;
                            r_state  <= ST_COMMIT;
                        end
                    end
                end
                ST_COMMIT: begin
                    r_spawn_valid <= 1'b1;
                    r_spawn_idx   <= r_slot;
                    r_state       <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Coordinates are only written on commit; inactive slots keep stale values.
    for (genvar i = 0; i < MAX_ENEMIES; i++) begin : g_slot
        logic [9:0] r_x;
        logic [9:0] r_y;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_x <= '0;
                r_y <= '0;
            end else if (w_commit && (r_slot == 4'(i))) begin
                r_x <= r_cand_x;
                r_y <= r_cand_y;
            end
        end
        assign enemy_x_flat[10*i +: 10] = r_x;
        assign enemy_y_flat[10*i +: 10] = r_y;
    end

    assign enemy_active = r_active;
    assign active_count = r_count;
    assign spawn_valid  = r_spawn_valid;
    assign spawn_idx    = r_spawn_idx;

endmodule

`default_nettype wire
